prog_delay_timer: RTL and testbench

//  Runtime-programmable delay/interval timer; successor to the fixed-divider delay loop.

---
 rtl/prog_delay_timer_pkg.sv | 23 ++
 rtl/prog_delay_timer_prescaler.sv | 40 ++++
 rtl/prog_delay_timer.sv | 132 +++++++++++++
 tb/tb_prog_delay_timer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_delay_timer_pkg.sv
// Shared definitions for the programmable delay timer: FSM state encoding
// and a constant-time clog2 used to size the prescaler.
package prog_delay_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Smallest number of bits able to hold 0..value-1; 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/prog_delay_timer_prescaler.sv
// Tick prescaler: counts enabled clocks and flags the clock on which the
// count wraps at PRESCALE-1. With PRESCALE==1 every clock is a tick.
module tick_prescaler
    import prog_delay_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic Clock,
    input  logic MR,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW_RAW = clog2(PRESCALE);
    localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_r;

    // Prescale counter: cleared by reset or clr, advances only while enabled.
    always_ff @(posedge Clock) begin
        if (MR) begin
            cnt_r <= {PW{1'b0}};
        end else if (clr) begin
            cnt_r <= {PW{1'b0}};
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= {PW{1'b0}};
            end else begin
                cnt_r <= cnt_r + PW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = (PRESCALE == 1) ? 1'b1 : (cnt_r == LAST);

endmodule

// File: rtl/prog_delay_timer.sv
// Runtime-programmable delay/interval timer. Counts Period ticks in
// one-shot or periodic mode with start/stop/pause/restart control.
// All outputs come straight from flops.
module prog_delay_timer
    import prog_delay_timer_pkg::*;
#(
    parameter int WIDTH          = 18,
    parameter int DEFAULT_PERIOD = 250000,
    parameter int PRESCALE       = 1
) (
    input  logic             Clock,
    input  logic             MR,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Pause,
    input  logic             Periodic,
    input  logic [WIDTH-1:0] Period,
    output logic             Timeout,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Count
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] period_s;
    logic             mode_r;
    logic             mode_s;
    logic             timeout_r;
    logic             timeout_s;
    logic             busy_r;
    logic             done_r;
    logic             tick_s;
    logic             pre_en_s;
    logic             pre_clr_s;

    // A programmed period of zero behaves as a one-tick period.
    function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
        return (p == ZERO) ? ONE : p;
    endfunction

    assign pre_en_s  = (state_r == ST_RUN) && !Pause;
    assign pre_clr_s = Stop || Start || (state_r != ST_RUN);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock (Clock),
        .MR    (MR),
        .clr   (pre_clr_s),
        .en    (pre_en_s),
        .tick  (tick_s)
    );

    // State register plus period/mode latches, count and status outputs.
    always_ff @(posedge Clock) begin
        if (MR) begin
            state_r   <= ST_IDLE;
            count_r   <= ZERO;
            period_r  <= WIDTH'(DEFAULT_PERIOD);
            mode_r    <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            period_r  <= period_s;
            mode_r    <= mode_s;
            timeout_r <= timeout_s;
            busy_r    <= (state_s == ST_RUN);
            done_r    <= (state_s == ST_DONE);
        end
    end

    // Next-state logic; Stop beats Start, Start beats Pause, Pause beats tick.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        period_s  = period_r;
        mode_s    = mode_r;
        timeout_s = 1'b0;
        if (Stop) begin
            state_s = ST_IDLE;
            count_s = ZERO;
        end else if (Start) begin
            state_s  = ST_RUN;
            count_s  = ZERO;
            period_s = clamp_period(Period);
            mode_s   = Periodic;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (!Pause && tick_s) begin
                        if (count_r == (period_r - ONE)) begin
                            timeout_s = 1'b1;
                            count_s   = ZERO;
                            if (mode_r) begin
                                period_s = clamp_period(Period);
                            end else begin
                                state_s = ST_DONE;
                            end
                        end else begin
                            count_s = count_r + ONE;
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    count_s = ZERO;
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = ZERO;
                end
            endcase
        end
    end

    assign Timeout = timeout_r;
    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Count   = count_r;

endmodule

// File: tb/tb_prog_delay_timer.sv
// Directed self-checking bench for prog_delay_timer (PRESCALE=1 and PRESCALE=4).
module tb_prog_delay_timer;

    logic        Clock;
    logic        MR;
    logic        Start;
    logic        Stop;
    logic        Pause;
    logic        Periodic;
    logic [17:0] Period;
    logic        Timeout;
    logic        Busy;
    logic        Done;
    logic [17:0] Count;
    logic        Timeout4;
    logic        Busy4;
    logic        Done4;
    logic [17:0] Count4;

    int n_checks;
    int n_errors;
    int gap;
    int pulses;

    prog_delay_timer #(.WIDTH(18), .DEFAULT_PERIOD(250000), .PRESCALE(1)) dut (
        .Clock(Clock), .MR(MR), .Start(Start), .Stop(Stop), .Pause(Pause),
        .Periodic(Periodic), .Period(Period), .Timeout(Timeout), .Busy(Busy),
        .Done(Done), .Count(Count)
    );

    prog_delay_timer #(.WIDTH(18), .DEFAULT_PERIOD(250000), .PRESCALE(4)) dut4 (
        .Clock(Clock), .MR(MR), .Start(Start), .Stop(Stop), .Pause(Pause),
        .Periodic(Periodic), .Period(Period), .Timeout(Timeout4), .Busy(Busy4),
        .Done(Done4), .Count(Count4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic clk();
        @(posedge Clock);
        #1;
    endtask

    // Clocks until Timeout (or Timeout4) is seen high; 0 if not within limit.
    task automatic clocks_to_timeout(input int limit, input bit use4, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            clk();
            if ((use4 ? Timeout4 : Timeout) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int clocks, output int p);
        p = 0;
        for (int i = 0; i < clocks; i++) begin
            clk();
            if (Timeout === 1'b1) p++;
        end
    endtask

    task automatic do_start(input logic [17:0] per, input logic per_mode);
        Period   = per;
        Periodic = per_mode;
        Start    = 1'b1;
        clk();
        Start    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        MR = 1'b1; Start = 1'b0; Stop = 1'b0; Pause = 1'b0;
        Periodic = 1'b0; Period = 18'd0;

        // 1 Reset
        clk(); clk();
        MR = 1'b0;
        check("reset_timeout", {31'd0, Timeout}, 32'd0);
        check("reset_busy",    {31'd0, Busy},    32'd0);
        check("reset_done",    {31'd0, Done},    32'd0);
        check("reset_count",   {14'd0, Count},   32'd0);
        check("reset_busy4",   {31'd0, Busy4},   32'd0);
        clk();
        check("idle_count",    {14'd0, Count},   32'd0);

        // 2 One-shot, Period=5
        do_start(18'd5, 1'b0);
        check("os_busy_start", {31'd0, Busy},  32'd1);
        check("os_count0",     {14'd0, Count}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            clk();
            check("os_no_timeout", {31'd0, Timeout}, 32'd0);
            check("os_count",      {14'd0, Count},   i);
        end
        clk();
        check("os_timeout",    {31'd0, Timeout}, 32'd1);
        check("os_busy_end",   {31'd0, Busy},    32'd0);
        check("os_done",       {31'd0, Done},    32'd1);
        check("os_count_end",  {14'd0, Count},   32'd0);
        clk();
        check("os_pulse_width", {31'd0, Timeout}, 32'd0);
        count_pulses(20, pulses);
        check("os_no_repeat",  pulses, 32'd0);
        check("os_done_sticky", {31'd0, Done}, 32'd1);

        // 3 Periodic, Period=3 then 6 from the next wrap
        do_start(18'd3, 1'b1);
        check("per_done_cleared", {31'd0, Done}, 32'd0);
        clocks_to_timeout(20, 1'b0, gap);
        check("per_gap1", gap, 32'd3);
        clk();
        Period = 18'd6;
        clocks_to_timeout(20, 1'b0, gap);
        check("per_gap_old", gap, 32'd2);
        clocks_to_timeout(20, 1'b0, gap);
        check("per_gap_new1", gap, 32'd6);
        clocks_to_timeout(20, 1'b0, gap);
        check("per_gap_new2", gap, 32'd6);
        check("per_busy", {31'd0, Busy}, 32'd1);
        Stop = 1'b1; clk(); Stop = 1'b0;
        check("per_stop_busy", {31'd0, Busy}, 32'd0);

        // 4 Pause, Period=10, frozen at Count=5 for 4 clocks
        do_start(18'd10, 1'b0);
        repeat (5) clk();
        check("pause_count_before", {14'd0, Count}, 32'd5);
        Pause = 1'b1;
        repeat (4) clk();
        check("pause_count_frozen", {14'd0, Count}, 32'd5);
        check("pause_busy",         {31'd0, Busy},  32'd1);
        Pause = 1'b0;
        clocks_to_timeout(20, 1'b0, gap);
        check("pause_expiry", gap + 9, 32'd14);

        // 5a Stop on the terminal cycle
        do_start(18'd4, 1'b0);
        repeat (3) clk();
        check("stop_pre_count", {14'd0, Count}, 32'd3);
        Stop = 1'b1; clk(); Stop = 1'b0;
        check("stop_timeout", {31'd0, Timeout}, 32'd0);
        check("stop_busy",    {31'd0, Busy},    32'd0);
        check("stop_done",    {31'd0, Done},    32'd0);
        check("stop_count",   {14'd0, Count},   32'd0);
        count_pulses(6, pulses);
        check("stop_no_pulse", pulses, 32'd0);

        // 5b Restart at Count=7 with Period=4
        do_start(18'd10, 1'b0);
        repeat (7) clk();
        check("restart_pre_count", {14'd0, Count}, 32'd7);
        do_start(18'd4, 1'b0);
        check("restart_no_timeout", {31'd0, Timeout}, 32'd0);
        check("restart_count",      {14'd0, Count},   32'd0);
        clocks_to_timeout(20, 1'b0, gap);
        check("restart_expiry", gap, 32'd4);

        // 6a Period=0 periodic -> every clock
        do_start(18'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            clk();
            check("p0_timeout", {31'd0, Timeout}, 32'd1);
            check("p0_count",   {14'd0, Count},   32'd0);
        end

        // 6b PRESCALE=4, Period=2 -> 8 clocks
        do_start(18'd2, 1'b0);
        clocks_to_timeout(20, 1'b1, gap);
        check("ps4_expiry", gap, 32'd8);
        clk();
        check("ps4_done", {31'd0, Done4}, 32'd1);
        check("ps4_busy", {31'd0, Busy4}, 32'd0);

        // 6c MR mid-RUN
        do_start(18'd100, 1'b1);
        repeat (10) clk();
        check("mr_pre_count", {14'd0, Count}, 32'd10);
        MR = 1'b1; clk(); MR = 1'b0;
        check("mr_timeout", {31'd0, Timeout}, 32'd0);
        check("mr_busy",    {31'd0, Busy},    32'd0);
        check("mr_done",    {31'd0, Done},    32'd0);
        check("mr_count",   {14'd0, Count},   32'd0);
        check("mr_busy4",   {31'd0, Busy4},   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
